reorder_buffer_mc: RTL and testbench

Parametrised in-order-retire reorder buffer for the out-of-order RV32 core; successor to the single-commit ROB. It allocates one entry per cycle from the decoder and accepts results on two write-back ports (RS, LSB). It retires up to COMMIT_W ready entries per cycle to the register file and LSB. On a mispredicted branch it raises a one-cycle flush with the redirect PC. Depth is 2^ROB_BIT; occupancy is tracked by an explicit counter, so full/empty are unambiguous.

---
 rtl/reorder_buffer_mc.sv | 219 +++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mc.sv
// ============================================================================
// Module   : reorder_buffer_mc
// Brief    : In-order-retire ROB, two write-back ports, up to COMMIT_W retires
//            per cycle, registered one-cycle flush on branch mispredict.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_TYPE_BIT
`define ROB_TYPE_BIT 2
`endif

module reorder_buffer_mc #(
    parameter int ROB_BIT  = 4,
    parameter int COMMIT_W = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       rdy_in,
    input  logic                       alloc_valid,
    input  logic                       alloc_ready_in,
    input  logic [`ROB_TYPE_BIT-1:0]   alloc_type,
    input  logic [4:0]                 alloc_rd,
    input  logic [31:0]                alloc_value,
    input  logic [31:0]                alloc_pc,
    input  logic [31:0]                alloc_jump,
    output logic [ROB_BIT-1:0]         alloc_id,
    output logic                       full,
    output logic                       empty,
    input  logic                       wb0_valid,
    input  logic [ROB_BIT-1:0]         wb0_id,
    input  logic [31:0]                wb0_value,
    input  logic                       wb1_valid,
    input  logic [ROB_BIT-1:0]         wb1_id,
    input  logic [31:0]                wb1_value,
    output logic [ROB_BIT-1:0]         head_id,
    output logic [COMMIT_W-1:0]        commit_valid,
    output logic [5*COMMIT_W-1:0]      commit_rd,
    output logic [32*COMMIT_W-1:0]     commit_val,
    output logic [ROB_BIT*COMMIT_W-1:0] commit_id,
    output logic                       commit_store,
    output logic [4:0]                 dep_rd,
    output logic [ROB_BIT-1:0]         dep_id,
    input  logic [ROB_BIT-1:0]         q1_id,
    output logic                       q1_ready,
    output logic [31:0]                q1_value,
    input  logic [ROB_BIT-1:0]         q2_id,
    output logic                       q2_ready,
    output logic [31:0]                q2_value,
    output logic                       flush,
    output logic [31:0]                new_pc,
    output logic [31:0]                retired_cnt
);

    localparam int                     c_DEPTH   = 1 << ROB_BIT;
    localparam logic [`ROB_TYPE_BIT-1:0] c_TYPE_RG = `ROB_TYPE_BIT'(0);
    localparam logic [`ROB_TYPE_BIT-1:0] c_TYPE_ST = `ROB_TYPE_BIT'(1);
    localparam logic [`ROB_TYPE_BIT-1:0] c_TYPE_BR = `ROB_TYPE_BIT'(2);

    logic [c_DEPTH-1:0]       r_busy;
    logic [c_DEPTH-1:0]       r_ready;
    logic [`ROB_TYPE_BIT-1:0] r_type  [c_DEPTH];
    logic [4:0]               r_rd    [c_DEPTH];
    logic [31:0]              r_value [c_DEPTH];
    logic [31:0]              r_jump  [c_DEPTH];
    logic [ROB_BIT-1:0]       r_head;
    logic [ROB_BIT-1:0]       r_tail;
    logic [ROB_BIT:0]         r_count;
    logic                     r_flush;
    logic [31:0]              r_new_pc;
    logic [31:0]              r_retired_cnt;

    logic                     w_alloc_acc;
    logic                     w_wb_en;
    logic [ROB_BIT-1:0]       w_head1;
    logic                     w_ret0;
    logic                     w_ret1;
    logic                     w_mis0;
    logic                     w_mis1;
    logic                     w_mis;
    logic [31:0]              w_mis_pc;
    logic [1:0]               w_nret;
    logic [1:0]               w_slot_ret;
    logic [ROB_BIT-1:0]       w_slot_idx [2];
    logic                     w_unused_pc;

    // The redirect target travels in the jump field, so the PC is not kept.
    assign w_unused_pc = ^alloc_pc;

    assign w_wb_en     = rdy_in && !r_flush;
    assign full        = (r_count == (ROB_BIT+1)'(c_DEPTH));
    assign empty       = (r_count == '0);
    assign w_alloc_acc = rdy_in && alloc_valid && !full && !r_flush;
    assign w_head1     = r_head + ROB_BIT'(1);

    assign w_ret0 = w_wb_en && r_busy[r_head] && r_ready[r_head];
    assign w_mis0 = (r_type[r_head] == c_TYPE_BR) && (r_value[r_head][0] != r_jump[r_head][0]);
    assign w_mis1 = (r_type[w_head1] == c_TYPE_BR) && (r_value[w_head1][0] != r_jump[w_head1][0]);

    generate
        if (COMMIT_W == 2) begin : g_dual_commit
            // Slot 1 never follows a store or a redirecting branch and is never a store.
            assign w_ret1 = w_ret0 && r_busy[w_head1] && r_ready[w_head1]
                         && (r_type[r_head] != c_TYPE_ST) && !w_mis0
                         && (r_type[w_head1] != c_TYPE_ST);
        end else begin : g_single_commit
            assign w_ret1 = 1'b0;
        end
    endgenerate

    assign w_mis    = (w_ret0 && w_mis0) || (w_ret1 && w_mis1);
    assign w_mis_pc = (w_ret0 && w_mis0) ? {r_jump[r_head][31:1], 1'b0}
                                         : {r_jump[w_head1][31:1], 1'b0};
    assign w_nret   = {1'b0, w_ret0} + {1'b0, w_ret1};

    assign w_slot_ret    = {w_ret1, w_ret0};
    assign w_slot_idx[0] = r_head;
    assign w_slot_idx[1] = w_head1;

    generate
        for (genvar k = 0; k < COMMIT_W; k++) begin : g_slot
            assign commit_valid[k] = w_slot_ret[k];
            assign commit_rd[5*k +: 5] =
                (w_slot_ret[k] && r_type[w_slot_idx[k]] == c_TYPE_RG) ? r_rd[w_slot_idx[k]] : 5'd0;
            assign commit_val[32*k +: 32] = w_slot_ret[k] ? r_value[w_slot_idx[k]] : 32'd0;
            assign commit_id[ROB_BIT*k +: ROB_BIT] = w_slot_ret[k] ? w_slot_idx[k] : '0;
        end
    endgenerate

    assign commit_store = w_ret0 && (r_type[r_head] == c_TYPE_ST);
    assign dep_rd = (w_alloc_acc && alloc_type == c_TYPE_RG) ? alloc_rd : 5'd0;
    assign dep_id = (w_alloc_acc && alloc_type == c_TYPE_RG) ? r_tail : '0;

    assign alloc_id    = r_tail;
    assign head_id     = r_head;
    assign flush       = r_flush;
    assign new_pc      = r_new_pc;
    assign retired_cnt = r_retired_cnt;

    // Operand lookup: committed-to-entry value first, then in-flight bypasses.
    function automatic logic [32:0] f_query(input logic [ROB_BIT-1:0] id);
        if (r_busy[id] && r_ready[id])
            return {1'b1, r_value[id]};
        if (w_wb_en && wb1_valid && wb1_id == id && r_busy[id])
            return {1'b1, wb1_value};
        if (w_wb_en && wb0_valid && wb0_id == id && r_busy[id])
            return {1'b1, wb0_value};
        if (w_alloc_acc && alloc_ready_in && r_tail == id)
            return {1'b1, alloc_value};
        return 33'd0;
    endfunction

    assign {q1_ready, q1_value} = f_query(q1_id);
    assign {q2_ready, q2_value} = f_query(q2_id);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy        <= '0;
            r_ready       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_flush       <= 1'b0;
            r_new_pc      <= 32'd0;
            r_retired_cnt <= 32'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_type[i]  <= '0;
                r_rd[i]    <= '0;
                r_value[i] <= '0;
                r_jump[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (r_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_flush <= 1'b0;
            end else begin
                if (w_alloc_acc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= alloc_ready_in;
                    r_type[r_tail]  <= alloc_type;
                    r_rd[r_tail]    <= alloc_rd;
                    r_value[r_tail] <= alloc_value;
                    r_jump[r_tail]  <= alloc_jump;
                    r_tail          <= r_tail + ROB_BIT'(1);
                end
                if (wb0_valid && r_busy[wb0_id]) begin
                    r_ready[wb0_id] <= 1'b1;
                    r_value[wb0_id] <= wb0_value;
                end
                // Later assignment gives wb1 priority on a shared ID.
                if (wb1_valid && r_busy[wb1_id]) begin
                    r_ready[wb1_id] <= 1'b1;
                    r_value[wb1_id] <= wb1_value;
                end
                if (w_ret0) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                end
                if (w_ret1) begin
                    r_busy[w_head1]  <= 1'b0;
                    r_ready[w_head1] <= 1'b0;
                end
                r_head        <= r_head + ROB_BIT'(w_nret);
                r_count       <= r_count + (ROB_BIT+1)'(w_alloc_acc) - (ROB_BIT+1)'(w_nret);
                r_retired_cnt <= r_retired_cnt + 32'(w_nret);
                r_flush       <= w_mis;
                if (w_mis)
                    r_new_pc <= w_mis_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer_mc.sv
// ============================================================================
// Module   : tb_reorder_buffer_mc
// Brief    : Directed self-checking bench for reorder_buffer_mc (DEPTH 16, 2 slots).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROB_TYPE_BIT
`define ROB_TYPE_BIT 2
`endif

module tb_reorder_buffer_mc;

    localparam logic [1:0] c_RG = 2'd0;
    localparam logic [1:0] c_ST = 2'd1;
    localparam logic [1:0] c_BR = 2'd2;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in;
    logic        alloc_valid, alloc_ready_in;
    logic [`ROB_TYPE_BIT-1:0] alloc_type;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_value, alloc_pc, alloc_jump;
    logic [3:0]  alloc_id;
    logic        full, empty;
    logic        wb0_valid, wb1_valid;
    logic [3:0]  wb0_id, wb1_id;
    logic [31:0] wb0_value, wb1_value;
    logic [3:0]  head_id;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [63:0] commit_val;
    logic [7:0]  commit_id;
    logic        commit_store;
    logic [4:0]  dep_rd;
    logic [3:0]  dep_id;
    logic [3:0]  q1_id, q2_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        flush;
    logic [31:0] new_pc, retired_cnt;

    int errors = 0;
    int checks = 0;

    reorder_buffer_mc #(.ROB_BIT(4), .COMMIT_W(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready_in(alloc_ready_in), .alloc_type(alloc_type),
        .alloc_rd(alloc_rd), .alloc_value(alloc_value), .alloc_pc(alloc_pc), .alloc_jump(alloc_jump),
        .alloc_id(alloc_id), .full(full), .empty(empty),
        .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_value(wb0_value),
        .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_value(wb1_value),
        .head_id(head_id), .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_val(commit_val), .commit_id(commit_id), .commit_store(commit_store),
        .dep_rd(dep_rd), .dep_id(dep_id),
        .q1_id(q1_id), .q1_ready(q1_ready), .q1_value(q1_value),
        .q2_id(q2_id), .q2_ready(q2_ready), .q2_value(q2_value),
        .flush(flush), .new_pc(new_pc), .retired_cnt(retired_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic clear_inputs();
        rdy_in = 1'b1; alloc_valid = 1'b0; alloc_ready_in = 1'b0; alloc_type = c_RG;
        alloc_rd = 5'd0; alloc_value = 32'd0; alloc_pc = 32'd0; alloc_jump = 32'd0;
        wb0_valid = 1'b0; wb0_id = 4'd0; wb0_value = 32'd0;
        wb1_valid = 1'b0; wb1_id = 4'd0; wb1_value = 32'd0;
        q1_id = 4'd0; q2_id = 4'd0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_alloc(input logic [1:0] t, input logic [4:0] rd, input logic rdy,
                             input logic [31:0] val, input logic [31:0] jmp);
        alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_ready_in = rdy;
        alloc_value = val; alloc_jump = jmp; alloc_pc = 32'h100;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n_in = 1'b0;
        #3;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0h want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h want 0", full); end
        checks++; if (alloc_id !== 4'd0) begin errors++; $display("FAIL reset_alloc_id: got %0h want 0", alloc_id); end
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL reset_commit: got %0h want 0", commit_valid); end
        checks++; if (flush !== 1'b0 || new_pc !== 32'd0) begin errors++; $display("FAIL reset_flush: got %0h/%0h want 0/0", flush, new_pc); end
        checks++; if (retired_cnt !== 32'd0) begin errors++; $display("FAIL reset_retired: got %0h want 0", retired_cnt); end
        #4;
        rst_n_in = 1'b1;
        step();
    endtask

    task automatic test_basic_retire();
        set_alloc(c_RG, 5'd1, 1'b0, 32'd0, 32'd0);
        #1;
        checks++; if (dep_rd !== 5'd1 || dep_id !== 4'd0) begin errors++; $display("FAIL dep_rename: got %0h/%0h want 1/0", dep_rd, dep_id); end
        step();
        set_alloc(c_RG, 5'd2, 1'b0, 32'd0, 32'd0); step();
        set_alloc(c_RG, 5'd3, 1'b0, 32'd0, 32'd0); step();
        clear_inputs();
        checks++; if (alloc_id !== 4'd3) begin errors++; $display("FAIL basic_tail: got %0h want 3", alloc_id); end
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_value = 32'd10;
        wb1_valid = 1'b1; wb1_id = 4'd1; wb1_value = 32'd20;
        #1;
        checks++; if (commit_valid !== 2'b00) begin errors++; $display("FAIL wb_same_cycle_retire: got %0h want 0", commit_valid); end
        step();
        clear_inputs();
        wb0_valid = 1'b1; wb0_id = 4'd2; wb0_value = 32'd30;
        #1;
        checks++; if (commit_valid !== 2'b11) begin errors++; $display("FAIL dual_valid: got %0h want 3", commit_valid); end
        checks++; if (commit_rd !== {5'd2, 5'd1}) begin errors++; $display("FAIL dual_rd: got %0h want %0h", commit_rd, {5'd2, 5'd1}); end
        checks++; if (commit_val !== {32'd20, 32'd10}) begin errors++; $display("FAIL dual_val: got %0h want %0h", commit_val, {32'd20, 32'd10}); end
        checks++; if (commit_id !== 8'h10) begin errors++; $display("FAIL dual_id: got %0h want 10", commit_id); end
        step();
        clear_inputs();
        #1;
        checks++; if (commit_valid !== 2'b01 || commit_val !== {32'd0, 32'd30} || commit_rd !== {5'd0, 5'd3})
            begin errors++; $display("FAIL single_retire: got v=%0h val=%0h rd=%0h want 1/1e/3", commit_valid, commit_val, commit_rd); end
        step();
        checks++; if (retired_cnt !== 32'd3 || empty !== 1'b1 || head_id !== 4'd3)
            begin errors++; $display("FAIL basic_end: got cnt=%0h empty=%0h head=%0h want 3/1/3", retired_cnt, empty, head_id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_alloc(c_RG, 5'(i + 1), 1'b0, 32'd0, 32'd0);
            step();
        end
        set_alloc(c_RG, 5'd17, 1'b1, 32'h77, 32'd0);
        #1;
        checks++; if (full !== 1'b1 || alloc_id !== 4'd0) begin errors++; $display("FAIL full_wrap: got full=%0h tail=%0h want 1/0", full, alloc_id); end
        checks++; if (dep_rd !== 5'd0) begin errors++; $display("FAIL full_reject: got dep_rd=%0h want 0", dep_rd); end
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_value = 32'h55;
        step();
        wb0_valid = 1'b0;
        #1;
        checks++; if (commit_valid !== 2'b01 || commit_val[31:0] !== 32'h55 || dep_rd !== 5'd0)
            begin errors++; $display("FAIL full_retire: got v=%0h val=%0h dep=%0h want 1/55/0", commit_valid, commit_val[31:0], dep_rd); end
        step();
        #1;
        checks++; if (full !== 1'b0 || dep_rd !== 5'd17 || dep_id !== 4'd0)
            begin errors++; $display("FAIL refill_alloc: got full=%0h dep=%0h id=%0h want 0/11/0", full, dep_rd, dep_id); end
        step();
        clear_inputs();
        checks++; if (full !== 1'b1 || alloc_id !== 4'd1 || head_id !== 4'd1 || retired_cnt !== 32'd1)
            begin errors++; $display("FAIL refill_state: got full=%0h tail=%0h head=%0h cnt=%0h want 1/1/1/1", full, alloc_id, head_id, retired_cnt); end
    endtask

    task automatic test_store_pair();
        do_reset();
        set_alloc(c_ST, 5'd4, 1'b0, 32'd0, 32'd0); step();
        set_alloc(c_ST, 5'd5, 1'b1, 32'd0, 32'd0); step();
        clear_inputs();
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_value = 32'h1;
        step();
        clear_inputs();
        #1;
        checks++; if (commit_valid !== 2'b01 || commit_store !== 1'b1 || commit_rd !== 10'd0)
            begin errors++; $display("FAIL store_first: got v=%0h st=%0h rd=%0h want 1/1/0", commit_valid, commit_store, commit_rd); end
        step();
        checks++; if (commit_valid !== 2'b01 || commit_store !== 1'b1 || commit_id[3:0] !== 4'd1)
            begin errors++; $display("FAIL store_second: got v=%0h st=%0h id=%0h want 1/1/1", commit_valid, commit_store, commit_id[3:0]); end
        step();
        checks++; if (commit_valid !== 2'b00 || commit_store !== 1'b0 || empty !== 1'b1)
            begin errors++; $display("FAIL store_done: got v=%0h st=%0h empty=%0h want 0/0/1", commit_valid, commit_store, empty); end
    endtask

    task automatic test_mispredict();
        do_reset();
        set_alloc(c_BR, 5'd0, 1'b0, 32'd0, 32'h0000_1235); step();
        set_alloc(c_RG, 5'd5, 1'b1, 32'd7, 32'd0); step();
        set_alloc(c_RG, 5'd6, 1'b1, 32'd8, 32'd0); step();
        clear_inputs();
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_value = 32'd0;
        step();
        clear_inputs();
        set_alloc(c_RG, 5'd9, 1'b1, 32'd1, 32'd0);
        #1;
        checks++; if (commit_valid !== 2'b01 || commit_rd !== 10'd0)
            begin errors++; $display("FAIL br_only_retire: got v=%0h rd=%0h want 1/0", commit_valid, commit_rd); end
        checks++; if (dep_rd !== 5'd9 || dep_id !== 4'd3) begin errors++; $display("FAIL wrong_path_alloc: got %0h/%0h want 9/3", dep_rd, dep_id); end
        step();
        #1;
        checks++; if (flush !== 1'b1 || new_pc !== 32'h0000_1234)
            begin errors++; $display("FAIL flush_raise: got flush=%0h pc=%0h want 1/1234", flush, new_pc); end
        checks++; if (commit_valid !== 2'b00 || dep_rd !== 5'd0)
            begin errors++; $display("FAIL flush_quiet: got v=%0h dep=%0h want 0/0", commit_valid, dep_rd); end
        step();
        clear_inputs();
        checks++; if (flush !== 1'b0 || empty !== 1'b1 || alloc_id !== 4'd0 || head_id !== 4'd0 || retired_cnt !== 32'd1)
            begin errors++; $display("FAIL flush_after: got f=%0h e=%0h t=%0h h=%0h c=%0h want 0/1/0/0/1", flush, empty, alloc_id, head_id, retired_cnt); end
    endtask

    task automatic test_bypass();
        set_alloc(c_RG, 5'd1, 1'b0, 32'd0, 32'd0); step();
        set_alloc(c_RG, 5'd2, 1'b0, 32'd0, 32'd0); step();
        clear_inputs();
        wb0_valid = 1'b1; wb0_id = 4'd1; wb0_value = 32'hDEAD;
        q1_id = 4'd1; q2_id = 4'd0;
        #1;
        checks++; if (q1_ready !== 1'b1 || q1_value !== 32'hDEAD)
            begin errors++; $display("FAIL byp_wb0: got %0h/%0h want 1/dead", q1_ready, q1_value); end
        checks++; if (q2_ready !== 1'b0) begin errors++; $display("FAIL byp_not_ready: got %0h want 0", q2_ready); end
        wb1_valid = 1'b1; wb1_id = 4'd1; wb1_value = 32'hBEEF;
        #1;
        checks++; if (q1_ready !== 1'b1 || q1_value !== 32'hBEEF)
            begin errors++; $display("FAIL byp_wb1_wins: got %0h/%0h want 1/beef", q1_ready, q1_value); end
        step();
        clear_inputs();
        q1_id = 4'd1; q2_id = 4'd2;
        set_alloc(c_RG, 5'd3, 1'b1, 32'h77, 32'd0);
        #1;
        checks++; if (q1_ready !== 1'b1 || q1_value !== 32'hBEEF)
            begin errors++; $display("FAIL stored_beef: got %0h/%0h want 1/beef", q1_ready, q1_value); end
        checks++; if (q2_ready !== 1'b1 || q2_value !== 32'h77)
            begin errors++; $display("FAIL byp_alloc: got %0h/%0h want 1/77", q2_ready, q2_value); end
        step();
        clear_inputs();
    endtask

    task automatic test_stall_and_async_reset();
        rdy_in = 1'b0;
        wb0_valid = 1'b1; wb0_id = 4'd0; wb0_value = 32'h99;
        set_alloc(c_RG, 5'd4, 1'b1, 32'd5, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (commit_valid !== 2'b00 || dep_rd !== 5'd0)
                begin errors++; $display("FAIL stall_pulses: got v=%0h dep=%0h want 0/0", commit_valid, dep_rd); end
            step();
        end
        q1_id = 4'd0;
        #1;
        checks++; if (alloc_id !== 4'd3 || head_id !== 4'd0 || retired_cnt !== 32'd1 || q1_ready !== 1'b0)
            begin errors++; $display("FAIL stall_hold: got t=%0h h=%0h c=%0h q=%0h want 3/0/1/0", alloc_id, head_id, retired_cnt, q1_ready); end
        rst_n_in = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || alloc_id !== 4'd0 || retired_cnt !== 32'd0 || commit_valid !== 2'b00)
            begin errors++; $display("FAIL async_reset: got e=%0h t=%0h c=%0h v=%0h want 1/0/0/0", empty, alloc_id, retired_cnt, commit_valid); end
        clear_inputs();
        #3;
        rst_n_in = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_retire();
        test_full_wrap();
        test_store_pair();
        test_mispredict();
        test_bypass();
        test_stall_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
